dmem_arbiter: RTL and testbench

Shares one data-memory port between `num_req_p` cores, using the same `mem_in_s` / `mem_out_s` valid/yumi handshake the cores already speak. It sits between the core array and the single data memory. It grants one core at a time using round-robin priority and keeps that grant until the transaction has fully completed. It sends that core's request and address to memory, and returns memory's acceptance and response to that core only.

---
 rtl/dmem_arbiter.sv | 158 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one data-memory port between
// num_req_p cores over the valid/yumi handshake. One transaction is owned
// from grant until the core accepts the response; request fields are
// latched at grant so the memory side never sees a core's live request.

package dmem_pkg;
    typedef struct packed {
        logic        valid;
        logic        wen;
        logic        byte_not_word;
        logic [31:0] write_data;
        logic        yumi;
    } mem_in_s;

    typedef struct packed {
        logic        valid;
        logic        yumi;
        logic [31:0] read_data;
    } mem_out_s;
endpackage

module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int num_req_p  = 4,
    parameter int id_width_p = $clog2(num_req_p)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  mem_in_s               core_to_arb_i [num_req_p],
    input  logic [31:0]           core_addr_i   [num_req_p],
    output mem_out_s              arb_to_core_o [num_req_p],
    output mem_in_s               arb_to_mem_o,
    output logic [31:0]           mem_addr_o,
    input  mem_out_s              mem_to_arb_i,
    output logic [id_width_p-1:0] grant_id_o,
    output logic                  busy_o
);

    typedef logic [id_width_p-1:0] id_t;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_e;

    state_e      state_q, state_d;
    id_t         grant_q, grant_d;
    id_t         last_grant_q, last_grant_d;
    logic        wen_q, wen_d;
    logic        bnw_q, bnw_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] addr_q, addr_d;

    id_t         winner;
    logic        winner_found;
    int          scan_idx;
    logic        resp_on;

    // Round-robin scan: first valid core after the last one granted wins.
    always_comb begin
        winner       = last_grant_q;
        winner_found = 1'b0;
        scan_idx     = 0;
        for (int k = 1; k <= num_req_p; k++) begin
            scan_idx = (int'(last_grant_q) + k) % num_req_p;
            if (!winner_found && core_to_arb_i[scan_idx].valid) begin
                winner_found = 1'b1;
                winner       = id_t'(scan_idx);
            end
        end
    end

    // Next-state logic plus the forwarding of acceptance and response.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        wen_d        = wen_q;
        bnw_d        = bnw_q;
        wdata_d      = wdata_q;
        addr_d       = addr_q;

        for (int j = 0; j < num_req_p; j++) begin
            arb_to_core_o[j] = '0;
        end
        arb_to_mem_o               = '0;
        arb_to_mem_o.wen           = wen_q;
        arb_to_mem_o.byte_not_word = bnw_q;
        arb_to_mem_o.write_data    = wdata_q;
        mem_addr_o                 = addr_q;
        grant_id_o                 = (state_q == IDLE) ? last_grant_q : grant_q;
        busy_o                     = (state_q != IDLE);

        // A response is visible to the owner once accepted, or in the
        // acceptance cycle itself when memory answers immediately.
        resp_on = (state_q == WAIT_RESP) ||
                  ((state_q == ISSUE) && mem_to_arb_i.yumi && mem_to_arb_i.valid);

        if (state_q == ISSUE) begin
            arb_to_mem_o.valid           = 1'b1;
            arb_to_core_o[grant_q].yumi  = mem_to_arb_i.yumi;
        end
        if (resp_on) begin
            arb_to_core_o[grant_q].valid     = mem_to_arb_i.valid;
            arb_to_core_o[grant_q].read_data = mem_to_arb_i.read_data;
            arb_to_mem_o.yumi                = core_to_arb_i[grant_q].yumi;
        end

        case (state_q)
            IDLE: begin
                if (winner_found) begin
                    state_d = ISSUE;
                    grant_d = winner;
                    wen_d   = core_to_arb_i[winner].wen;
                    bnw_d   = core_to_arb_i[winner].byte_not_word;
                    wdata_d = core_to_arb_i[winner].write_data;
                    addr_d  = core_addr_i[winner];
                end
            end
            ISSUE: begin
                if (mem_to_arb_i.yumi) begin
                    if (mem_to_arb_i.valid && core_to_arb_i[grant_q].yumi) begin
                        state_d      = IDLE;
                        last_grant_d = grant_q;
                    end else begin
                        state_d = WAIT_RESP;
                    end
                end
            end
            WAIT_RESP: begin
                if (mem_to_arb_i.valid && core_to_arb_i[grant_q].yumi) begin
                    state_d      = IDLE;
                    last_grant_d = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, grant and holding registers; reset abandons any transaction.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= id_t'(num_req_p - 1);
            wen_q        <= 1'b0;
            bnw_q        <= 1'b0;
            wdata_q      <= '0;
            addr_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            wen_q        <= wen_d;
            bnw_q        <= bnw_d;
            wdata_q      <= wdata_d;
            addr_q       <= addr_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios plus a randomized run
// compared against a transaction-level reference model.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset;
    mem_in_s     core_in   [N];
    logic [31:0] core_addr [N];
    mem_out_s    core_out  [N];
    mem_in_s     mem_req;
    logic [31:0] mem_addr;
    mem_out_s    mem_rsp;
    logic [1:0]  gid;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.num_req_p(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .core_to_arb_i(core_in),
        .core_addr_i  (core_addr),
        .arb_to_core_o(core_out),
        .arb_to_mem_o (mem_req),
        .mem_addr_o   (mem_addr),
        .mem_to_arb_i (mem_rsp),
        .grant_id_o   (gid),
        .busy_o       (busy)
    );

    // Reference model: owner of the port, whether memory has taken the
    // request, and the latched request copy.
    logic        m_busy, m_acc;
    int          m_owner, m_last;
    mem_in_s     m_lat;
    logic [31:0] m_addr;
    int          m_win;
    logic        m_found, m_resp;
    mem_in_s     exp_mem;
    mem_out_s    exp_core [N];
    int          exp_gid;

    always_comb begin
        m_found = 1'b0;
        m_win   = 0;
        for (int k = 1; k <= N; k++) begin
            if (!m_found && core_in[(m_last + k) % N].valid) begin
                m_found = 1'b1;
                m_win   = (m_last + k) % N;
            end
        end
    end

    always_comb begin
        m_resp = m_busy && (m_acc || (mem_rsp.yumi && mem_rsp.valid));
        exp_mem = '0;
        exp_mem.valid         = m_busy && !m_acc;
        exp_mem.wen           = m_lat.wen;
        exp_mem.byte_not_word = m_lat.byte_not_word;
        exp_mem.write_data    = m_lat.write_data;
        exp_mem.yumi          = m_resp && core_in[m_owner].yumi;
        for (int j = 0; j < N; j++) exp_core[j] = '0;
        if (m_busy) begin
            exp_core[m_owner].yumi = !m_acc && mem_rsp.yumi;
            if (m_resp) begin
                exp_core[m_owner].valid     = mem_rsp.valid;
                exp_core[m_owner].read_data = mem_rsp.read_data;
            end
        end
        exp_gid = m_busy ? m_owner : m_last;
    end

    always @(posedge clk) begin
        if (!reset) begin
            m_busy  <= 1'b0;
            m_acc   <= 1'b0;
            m_owner <= 0;
            m_last  <= N - 1;
            m_lat   <= '0;
            m_addr  <= '0;
        end else if (!m_busy) begin
            if (m_found) begin
                m_busy  <= 1'b1;
                m_acc   <= 1'b0;
                m_owner <= m_win;
                m_lat   <= core_in[m_win];
                m_addr  <= core_addr[m_win];
            end
        end else begin
            if (!m_acc && mem_rsp.yumi) m_acc <= 1'b1;
            if (m_resp && mem_rsp.valid && core_in[m_owner].yumi) begin
                m_busy <= 1'b0;
                m_last <= m_owner;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int j = 0; j < N; j++) begin
            core_in[j]   = '0;
            core_addr[j] = '0;
        end
        mem_rsp = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++;
        if (busy !== 1'b0 || gid !== 2'd3) begin
            errors++; $display("FAIL reset_state busy=%b gid=%0d want busy=0 gid=3", busy, gid);
        end
        checks++;
        if (mem_req !== '0 || mem_addr !== 32'h0) begin
            errors++; $display("FAIL reset_mem got req=%h addr=%h want 0", mem_req, mem_addr);
        end
        for (int j = 0; j < N; j++) begin
            checks++;
            if (core_out[j] !== '0) begin
                errors++; $display("FAIL reset_core%0d got %h want 0", j, core_out[j]);
            end
        end
    endtask

    task automatic test_single_load();
        apply_reset();
        for (int j = 0; j < N; j++) core_in[j].yumi = 1'b1;
        core_in[0].valid = 1'b1;
        core_addr[0]     = 32'h40;
        #1;
        checks++;
        if (mem_req.valid !== 1'b0) begin
            errors++; $display("FAIL load_c0_memvalid got %b want 0", mem_req.valid);
        end
        tick();
        core_in[0].valid = 1'b0;
        core_addr[0]     = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (mem_req.valid !== 1'b1 || mem_addr !== 32'h40 || mem_req.wen !== 1'b0 || core_out[0].yumi !== 1'b0) begin
            errors++; $display("FAIL load_issue got v=%b addr=%h wen=%b y=%b want 1 40 0 0",
                               mem_req.valid, mem_addr, mem_req.wen, core_out[0].yumi);
        end
        tick();
        tick();
        mem_rsp.yumi = 1'b1;
        #1;
        checks++;
        if (core_out[0].yumi !== 1'b1 || core_out[0].valid !== 1'b0) begin
            errors++; $display("FAIL load_yumi got y=%b v=%b want 1 0", core_out[0].yumi, core_out[0].valid);
        end
        for (int j = 1; j < N; j++) begin
            checks++;
            if (core_out[j] !== '0) begin
                errors++; $display("FAIL load_other%0d got %h want 0", j, core_out[j]);
            end
        end
        tick();
        mem_rsp.yumi = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1 || mem_req.valid !== 1'b0 || core_out[0] !== '0) begin
            errors++; $display("FAIL load_wait got busy=%b v=%b core=%h want 1 0 0", busy, mem_req.valid, core_out[0]);
        end
        tick();
        tick();
        mem_rsp.valid     = 1'b1;
        mem_rsp.read_data = 32'hDEADBEEF;
        #1;
        checks++;
        if (core_out[0].valid !== 1'b1 || core_out[0].read_data !== 32'hDEADBEEF || mem_req.yumi !== 1'b1) begin
            errors++; $display("FAIL load_resp got v=%b rd=%h my=%b want 1 deadbeef 1",
                               core_out[0].valid, core_out[0].read_data, mem_req.yumi);
        end
        for (int j = 1; j < N; j++) begin
            checks++;
            if (core_out[j] !== '0) begin
                errors++; $display("FAIL load_resp_other%0d got %h want 0", j, core_out[j]);
            end
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (busy !== 1'b0 || gid !== 2'd0 || core_out[0] !== '0) begin
            errors++; $display("FAIL load_done got busy=%b gid=%0d core=%h want 0 0 0", busy, gid, core_out[0]);
        end
    endtask

    task automatic test_contend();
        int order [5] = '{0, 1, 2, 3, 0};
        int n = 0;
        apply_reset();
        for (int j = 0; j < N; j++) begin
            core_in[j].valid = 1'b1;
            core_in[j].yumi  = 1'b1;
            core_addr[j]     = 32'h100 * (j + 1);
        end
        mem_rsp.yumi  = 1'b1;
        mem_rsp.valid = 1'b1;
        for (int cyc = 0; cyc < 40 && n < 5; cyc++) begin
            #1;
            if (mem_req.valid === 1'b1) begin
                checks++;
                if (gid !== 2'(order[n]) || mem_addr !== 32'h100 * (order[n] + 1)) begin
                    errors++; $display("FAIL contend_%0d got gid=%0d addr=%h want gid=%0d addr=%h",
                                       n, gid, mem_addr, order[n], 32'h100 * (order[n] + 1));
                end
                n++;
            end
            tick();
        end
        checks++;
        if (n != 5) begin
            errors++; $display("FAIL contend_count got %0d grants want 5", n);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_same_cycle();
        apply_reset();
        core_in[2].valid         = 1'b1;
        core_in[2].wen           = 1'b1;
        core_in[2].byte_not_word = 1'b1;
        core_in[2].write_data    = 32'h12345678;
        core_addr[2]             = 32'h2000;
        tick();
        core_in[2]      = '0;
        core_in[2].yumi = 1'b1;
        mem_rsp.yumi    = 1'b1;
        mem_rsp.valid   = 1'b1;
        #1;
        checks++;
        if (mem_req.valid !== 1'b1 || mem_req.wen !== 1'b1 || mem_req.byte_not_word !== 1'b1 ||
            mem_req.write_data !== 32'h12345678 || mem_addr !== 32'h2000) begin
            errors++; $display("FAIL store_fields got req=%h addr=%h want wen=1 bnw=1 wd=12345678 addr=2000",
                               mem_req, mem_addr);
        end
        checks++;
        if (core_out[2].yumi !== 1'b1 || core_out[2].valid !== 1'b1 || mem_req.yumi !== 1'b1) begin
            errors++; $display("FAIL store_same got cy=%b cv=%b my=%b want 1 1 1",
                               core_out[2].yumi, core_out[2].valid, mem_req.yumi);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (busy !== 1'b0 || mem_req.valid !== 1'b0 || gid !== 2'd2) begin
            errors++; $display("FAIL store_idle got busy=%b v=%b gid=%0d want 0 0 2", busy, mem_req.valid, gid);
        end
    endtask

    task automatic test_stall();
        apply_reset();
        core_in[1].valid = 1'b1;
        core_addr[1]     = 32'h80;
        tick();
        core_in[1].valid = 1'b0;
        mem_rsp.yumi     = 1'b1;
        tick();
        mem_rsp.yumi      = 1'b0;
        mem_rsp.valid     = 1'b1;
        mem_rsp.read_data = 32'hA5A5_0F0F;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (busy !== 1'b1 || mem_req.yumi !== 1'b0 || core_out[1].valid !== 1'b1 ||
                core_out[1].read_data !== 32'hA5A5_0F0F) begin
                errors++; $display("FAIL stall_%0d got busy=%b my=%b cv=%b rd=%h want 1 0 1 a5a50f0f",
                                   c, busy, mem_req.yumi, core_out[1].valid, core_out[1].read_data);
            end
            tick();
        end
        core_in[1].yumi = 1'b1;
        #1;
        checks++;
        if (mem_req.yumi !== 1'b1) begin
            errors++; $display("FAIL stall_release got my=%b want 1", mem_req.yumi);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (busy !== 1'b0 || gid !== 2'd1) begin
            errors++; $display("FAIL stall_done got busy=%b gid=%0d want 0 1", busy, gid);
        end
    endtask

    task automatic test_reset_mid();
        logic bad;
        apply_reset();
        core_in[2].valid = 1'b1;
        core_addr[2]     = 32'h222;
        tick();
        core_in[2].valid = 1'b0;
        mem_rsp.yumi     = 1'b1;
        tick();
        mem_rsp.yumi = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1 || gid !== 2'd2) begin
            errors++; $display("FAIL rmid_pre got busy=%b gid=%0d want 1 2", busy, gid);
        end
        reset         = 1'b0;
        mem_rsp.valid = 1'b1;
        tick();
        reset = 1'b1;
        clear_inputs();
        #1;
        bad = (mem_req.valid !== 1'b0) || (mem_req.yumi !== 1'b0);
        for (int j = 0; j < N; j++) bad = bad || (core_out[j].valid !== 1'b0) || (core_out[j].yumi !== 1'b0);
        checks++;
        if (busy !== 1'b0 || gid !== 2'd3 || bad) begin
            errors++; $display("FAIL rmid_post got busy=%b gid=%0d handshake_nonzero=%b want 0 3 0", busy, gid, bad);
        end
        core_in[1].valid = 1'b1;
        core_addr[1]     = 32'h111;
        tick();
        core_in[1].valid = 1'b0;
        #1;
        checks++;
        if (gid !== 2'd1 || mem_req.valid !== 1'b1 || mem_addr !== 32'h111) begin
            errors++; $display("FAIL rmid_regrant got gid=%0d v=%b addr=%h want 1 1 111", gid, mem_req.valid, mem_addr);
        end
        core_in[1].yumi = 1'b1;
        mem_rsp.yumi    = 1'b1;
        mem_rsp.valid   = 1'b1;
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_late_request();
        apply_reset();
        for (int j = 0; j < N; j++) core_in[j].yumi = 1'b1;
        core_in[3].valid = 1'b1;
        core_addr[3]     = 32'h300;
        tick();
        core_in[3].valid = 1'b0;
        core_in[0].valid = 1'b1;
        core_addr[0]     = 32'hC0;
        mem_rsp.yumi     = 1'b1;
        mem_rsp.valid    = 1'b1;
        #1;
        checks++;
        if (gid !== 2'd3 || mem_req.valid !== 1'b1 || mem_addr !== 32'h300) begin
            errors++; $display("FAIL late_first got gid=%0d v=%b addr=%h want 3 1 300", gid, mem_req.valid, mem_addr);
        end
        tick();
        mem_rsp = '0;
        #1;
        checks++;
        if (busy !== 1'b0 || mem_req.valid !== 1'b0) begin
            errors++; $display("FAIL late_gap got busy=%b v=%b want 0 0", busy, mem_req.valid);
        end
        tick();
        core_in[0].valid = 1'b0;
        #1;
        checks++;
        if (gid !== 2'd0 || mem_req.valid !== 1'b1 || mem_addr !== 32'hC0) begin
            errors++; $display("FAIL late_second got gid=%0d v=%b addr=%h want 0 1 c0", gid, mem_req.valid, mem_addr);
        end
        mem_rsp.yumi  = 1'b1;
        mem_rsp.valid = 1'b1;
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 63) != 0);
            for (int j = 0; j < N; j++) begin
                core_in[j].valid         = ($urandom_range(0, 2) == 0);
                core_in[j].wen           = 1'($urandom);
                core_in[j].byte_not_word = 1'($urandom);
                core_in[j].write_data    = $urandom;
                core_in[j].yumi          = ($urandom_range(0, 2) != 0);
                core_addr[j]             = $urandom;
            end
            mem_rsp.yumi      = ($urandom_range(0, 2) == 0);
            mem_rsp.valid     = ($urandom_range(0, 2) == 0);
            mem_rsp.read_data = $urandom;
            #1;
            checks++;
            if (mem_req !== exp_mem || mem_addr !== m_addr) begin
                errors++; $display("FAIL rand_mem cyc %0d got req=%h addr=%h want req=%h addr=%h",
                                   c, mem_req, mem_addr, exp_mem, m_addr);
            end
            checks++;
            if (busy !== m_busy || gid !== 2'(exp_gid)) begin
                errors++; $display("FAIL rand_ctl cyc %0d got busy=%b gid=%0d want busy=%b gid=%0d",
                                   c, busy, gid, m_busy, exp_gid);
            end
            for (int j = 0; j < N; j++) begin
                checks++;
                if (core_out[j] !== exp_core[j]) begin
                    errors++; $display("FAIL rand_core%0d cyc %0d got %h want %h", j, c, core_out[j], exp_core[j]);
                end
            end
            tick();
        end
        reset = 1'b1;
        clear_inputs();
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        test_reset();
        test_single_load();
        test_contend();
        test_same_cycle();
        test_stall();
        test_reset_mid();
        test_late_request();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
